cordic_range_reduce: RTL and testbench
======================================

CORDIC_RANGE_REDUCE -- requirements
Module: cordic_range_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the reduced angle and of the sin/cos words, signed Q1.6.
REQ-002 SHALL have parameter IN_WIDTH, default 10: width of the full-range input angle, signed Q3.6 radians.
REQ-003 SHALL have parameter CORDIC_LAT, default 12: latency in cycles of the downstream CORDIC, from out_angle to valid cos_in/sin_in.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  in_angle valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_angle.
REQ-008 SHALL have port in_angle  input  IN_WIDTH  full-range angle, Q3.6.
REQ-009 SHALL have port out_valid  output  1  out_angle valid.
REQ-010 SHALL have port out_angle  output  DATA_WIDTH  reduced angle to the CORDIC, Q1.6, range [-pi/2, pi/2].
REQ-011 SHALL have port cos_in, sin_in  input  DATA_WIDTH each  CORDIC results, Q1.6.
REQ-012 SHALL have port res_valid  output  1  corrected result valid.
REQ-013 SHALL have port cos_out, sin_out  output  DATA_WIDTH each  quadrant-corrected results, Q1.6.
REQ-014 SHALL have port res_err  output  1  input was out of range; aligned with res_valid.

Function
REQ-015 SHALL use these constants: PI = 201 and PI_HALF = 101 in Q3.6 LSBs; TWO_PI = 402.
REQ-016 SHALL accept a sample in any cycle where in_valid and in_ready are both 1.
REQ-017 SHALL drive in_ready to 1 in every cycle in which rst is 1; there is no backpressure, because the downstream CORDIC is fully pipelined.
REQ-018 SHALL pre-condition the input to [-PI, PI]; the pre-conditioning rule is set by REQ-030 and REQ-031.
REQ-019 SHALL reduce the pre-conditioned angle a as follows:
- a > PI_HALF: out_angle = a - PI, flip = 1.
- a < -PI_HALF: out_angle = a + PI, flip = 1.
- otherwise: out_angle = a, flip = 0.
- Boundaries: ±101 gives flip = 0; ±102 gives flip = 1.
REQ-020 SHALL register out_angle and out_valid, giving 1 cycle of latency from acceptance.
REQ-021 SHALL hold out_angle at its last value when out_valid is 0.
REQ-022 SHALL carry {valid, flip, err} through a CORDIC_LAT-deep shift register in step with the CORDIC pipeline.
REQ-023 SHALL generate the corrected result at the tail of the shift register:
- Register cos_out = flip ? -cos_in : cos_in, and sin_out likewise.
- Register res_valid and res_err from the same stage.
- Total latency from acceptance to res_valid is CORDIC_LAT+2 cycles (14 at defaults).
REQ-024 SHALL saturate the negation of -128 to +127.
REQ-025 SHALL hold cos_out, sin_out and res_err at their last values when res_valid is 0.
REQ-026 SHALL sustain 1 sample/cycle, preserve sample order, and never drop or duplicate a sample.

Reset
REQ-027 SHALL, while rst = 0 at a clock edge, clear out_valid, res_valid, res_err, out_angle, cos_out, sin_out and all shift-register bits to 0, and drive in_ready to 0.
REQ-028 SHALL discard all in-flight samples on reset asserted mid-stream; no res_valid pulse may occur for a pre-reset sample after reset is released.
REQ-029 SHALL allow the first acceptance at the first clock edge where rst = 1.

Configuration
REQ-030 SHALL, with macro CORDIC_RR_SAT_EN defined, clamp an input outside [-201, 201] to ±201 and set err = 1.
REQ-031 SHALL, with CORDIC_RR_SAT_EN undefined, wrap an input outside [-201, 201] by a single ±TWO_PI adjustment and set err = 0; one adjustment suffices for IN_WIDTH = 10.

Verification
REQ-032 SHALL cover: in_angle = 64 -> out_angle = 64 one cycle later; drive cos_in = 35, sin_in = 54 at the aligned tail cycle -> cos_out = 35, sin_out = 54, res_valid at cycle 14.
REQ-033 SHALL cover: in_angle = 150 -> out_angle = -51, flip = 1; drive cos_in = 55, sin_in = -31 -> cos_out = -55, sin_out = 31.
REQ-034 SHALL cover: in_angle = ±101 -> out_angle = ±101, no negation; in_angle = -102 -> out_angle = 99, negated outputs.
REQ-035 SHALL cover: in_angle = 300, with CORDIC_RR_SAT_EN defined -> out_angle = 0, res_err = 1; with it undefined -> out_angle = 99, flip = 1, res_err = 0.
REQ-036 SHALL cover: flip = 1 with cos_in = -128 -> cos_out = 127.
REQ-037 SHALL cover: back-to-back samples every cycle for 20 cycles, with rst pulsed low at cycle 8 -> all state cleared, res_valid = 0 until 14 cycles after the first post-reset acceptance, and output order matches input order.

Source files
------------

// File: rtl/cordic_range_reduce.sv
// Range reduction front-end and quadrant correction back-end around a pipelined CORDIC.
// Build option: define CORDIC_RR_SAT_EN to clamp out-of-range inputs and flag them instead of wrapping.
module cordic_range_reduce #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IN_WIDTH   = 10,
  parameter int unsigned CORDIC_LAT = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   in_angle,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_angle,
  input  logic signed [DATA_WIDTH-1:0] cos_in,
  input  logic signed [DATA_WIDTH-1:0] sin_in,
  output logic                         res_valid,
  output logic signed [DATA_WIDTH-1:0] cos_out,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic                         res_err
);

  // Two guard bits so the +/-TWO_PI wrap never overflows the working width
  localparam int unsigned CALC_W = IN_WIDTH + 2;

  localparam logic signed [CALC_W-1:0] PI          = CALC_W'(201);
  localparam logic signed [CALC_W-1:0] NEG_PI      = -CALC_W'(201);
  localparam logic signed [CALC_W-1:0] PI_HALF     = CALC_W'(101);
  localparam logic signed [CALC_W-1:0] NEG_PI_HALF = -CALC_W'(101);
  localparam logic signed [CALC_W-1:0] TWO_PI      = CALC_W'(402);

  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic valid;
    logic flip;
    logic err;
  } tag_t;

  logic                     accept;
  logic signed [CALC_W-1:0] in_ext;
  logic signed [CALC_W-1:0] pre_angle;
  logic signed [CALC_W-1:0] red_angle;
  logic                     pre_err;
  logic                     red_flip;

  logic                     out_flip;
  logic                     out_err;
  tag_t                     tag_pipe [CORDIC_LAT];
  tag_t                     tail;

  // Negation that maps the most negative code to the most positive one
  function automatic logic signed [DATA_WIDTH-1:0] neg_sat(
    input logic signed [DATA_WIDTH-1:0] v
  );
    if (v == SMIN) begin
      return SMAX;
    end
    return -v;
  endfunction

  // No backpressure: the CORDIC downstream is fully pipelined
  assign in_ready = rst;
  assign accept   = in_valid && in_ready;

  // Pre-condition to [-PI, PI], then fold into [-PI/2, PI/2]
  always_comb begin
    in_ext    = CALC_W'(in_angle);
    pre_angle = in_ext;
    pre_err   = 1'b0;
    red_angle = '0;
    red_flip  = 1'b0;
`ifdef CORDIC_RR_SAT_EN
    if (in_ext > PI) begin
      pre_angle = PI;
      pre_err   = 1'b1;
    end else if (in_ext < NEG_PI) begin
      pre_angle = NEG_PI;
      pre_err   = 1'b1;
    end
`else
    if (in_ext > PI) begin
      pre_angle = in_ext - TWO_PI;
    end else if (in_ext < NEG_PI) begin
      pre_angle = in_ext + TWO_PI;
    end
`endif
    if (pre_angle > PI_HALF) begin
      red_angle = pre_angle - PI;
      red_flip  = 1'b1;
    end else if (pre_angle < NEG_PI_HALF) begin
      red_angle = pre_angle + PI;
      red_flip  = 1'b1;
    end else begin
      red_angle = pre_angle;
      red_flip  = 1'b0;
    end
  end

  // Reduced-angle output stage; payload holds while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_angle <= '0;
      out_flip  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        out_angle <= DATA_WIDTH'(red_angle);
        out_flip  <= red_flip;
        out_err   <= pre_err;
      end
    end
  end

  // Sideband tags travel alongside the CORDIC pipeline
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(CORDIC_LAT); i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: out_valid, flip: out_flip, err: out_err};
      for (int i = 1; i < int'(CORDIC_LAT); i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tail = tag_pipe[CORDIC_LAT-1];

  // Quadrant correction of the CORDIC result; payload holds while idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      res_valid <= 1'b0;
      res_err   <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
    end else begin
      res_valid <= tail.valid;
      if (tail.valid) begin
        cos_out <= tail.flip ? neg_sat(cos_in) : cos_in;
        sin_out <= tail.flip ? neg_sat(sin_in) : sin_in;
        res_err <= tail.err;
      end
    end
  end

endmodule

// File: tb/tb_cordic_range_reduce.sv
// Directed bench for cordic_range_reduce with a delay-line stand-in for the CORDIC.
module tb_cordic_range_reduce;

  localparam int unsigned DW  = 8;
  localparam int unsigned IW  = 10;
  localparam int unsigned LAT = 12;

  // Back-to-back stream: angle, hand-reduced angle, hand-derived flip
  localparam int ANG   [20] = '{10, -20, 101, 102, -101, -102, 150, -150, 64, 201,
                                -201, 0, 120, -130, 50, -60, 180, -180, 100, 5};
  localparam int RED   [20] = '{10, -20, 101, -99, -101, 99, -51, 51, 64, 0,
                                0, 0, -81, 71, 50, -60, -21, 21, 100, 5};
  localparam int FLIP  [20] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1,
                                1, 0, 1, 1, 0, 0, 1, 1, 0, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, in_valid, in_ready, out_valid, res_valid, res_err;
  logic signed [IW-1:0] in_angle;
  logic signed [DW-1:0] out_angle, cos_in, sin_in, cos_out, sin_out;
  logic signed [DW-1:0] cur_cos, cur_sin;
  logic signed [DW-1:0] cchain [LAT+1];
  logic signed [DW-1:0] schain [LAT+1];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic                 ov;
    logic signed [DW-1:0] oa;
    logic                 rv_early;
    logic                 rv;
    logic signed [DW-1:0] co;
    logic signed [DW-1:0] so;
    logic                 re;
    logic                 rv_after;
    logic signed [DW-1:0] co_after;
    logic signed [DW-1:0] oa_after;
  } obs_t;

  cordic_range_reduce #(.DATA_WIDTH(DW), .IN_WIDTH(IW), .CORDIC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_angle(in_angle),
    .out_valid(out_valid), .out_angle(out_angle), .cos_in(cos_in), .sin_in(sin_in),
    .res_valid(res_valid), .cos_out(cos_out), .sin_out(sin_out), .res_err(res_err)
  );

  // Stand-in CORDIC: returns the result chosen at input time, aligned to the DUT pipeline
  always @(posedge clk) begin
    cchain[0] <= cur_cos;
    schain[0] <= cur_sin;
    for (int i = 1; i <= int'(LAT); i++) begin
      cchain[i] <= cchain[i-1];
      schain[i] <= schain[i-1];
    end
  end
  assign cos_in = cchain[LAT];
  assign sin_in = schain[LAT];

  task automatic send(input int ang, input int c, input int s, output obs_t o);
    @(negedge clk);
    in_valid = 1'b1;
    in_angle = IW'(ang);
    cur_cos  = DW'(c);
    cur_sin  = DW'(s);
    @(negedge clk);
    in_valid = 1'b0;
    cur_cos  = '0;
    cur_sin  = '0;
    o.ov = out_valid;
    o.oa = out_angle;
    repeat (LAT) @(negedge clk);
    o.rv_early = res_valid;
    @(negedge clk);
    o.rv = res_valid;
    o.co = cos_out;
    o.so = sin_out;
    o.re = res_err;
    @(negedge clk);
    o.rv_after = res_valid;
    o.co_after = cos_out;
    o.oa_after = out_angle;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_angle = '0; cur_cos = '0; cur_sin = '0;
    repeat (3) @(negedge clk);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset in_ready got %b want 0", in_ready); end
    n_vec++; if (out_valid !== 1'b0 || res_valid !== 1'b0 || res_err !== 1'b0) begin
      n_err++; $display("FAIL reset valids got ov=%b rv=%b re=%b want 0", out_valid, res_valid, res_err); end
    n_vec++; if (out_angle !== 0 || cos_out !== 0 || sin_out !== 0) begin
      n_err++; $display("FAIL reset data got oa=%0d co=%0d so=%0d want 0", out_angle, cos_out, sin_out); end
    // First acceptance on the very first edge with reset released
    rst = 1'b1; in_valid = 1'b1; in_angle = IW'(20);
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release in_ready got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_angle !== 20) begin
      n_err++; $display("FAIL first_accept got ov=%b oa=%0d want 1/20", out_valid, out_angle); end
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic test_basic();
    obs_t o;
    send(64, 35, 54, o);
    n_vec++; if (o.ov !== 1'b1 || o.oa !== 64) begin n_err++; $display("FAIL basic out got ov=%b oa=%0d want 1/64", o.ov, o.oa); end
    n_vec++; if (o.rv_early !== 1'b0) begin n_err++; $display("FAIL basic early res_valid got %b want 0", o.rv_early); end
    n_vec++; if (o.rv !== 1'b1 || o.co !== 35 || o.so !== 54 || o.re !== 1'b0) begin
      n_err++; $display("FAIL basic res got rv=%b co=%0d so=%0d re=%b want 1/35/54/0", o.rv, o.co, o.so, o.re); end
    n_vec++; if (o.rv_after !== 1'b0 || o.co_after !== 35 || o.oa_after !== 64) begin
      n_err++; $display("FAIL basic hold got rv=%b co=%0d oa=%0d want 0/35/64", o.rv_after, o.co_after, o.oa_after); end
  endtask

  task automatic test_flip();
    obs_t o;
    send(150, 55, -31, o);
    n_vec++; if (o.oa !== -51) begin n_err++; $display("FAIL flip out_angle got %0d want -51", o.oa); end
    n_vec++; if (o.rv !== 1'b1 || o.co !== -55 || o.so !== 31) begin
      n_err++; $display("FAIL flip res got rv=%b co=%0d so=%0d want 1/-55/31", o.rv, o.co, o.so); end
  endtask

  task automatic test_boundary();
    obs_t o;
    send(101, 20, 30, o);
    n_vec++; if (o.oa !== 101 || o.co !== 20 || o.so !== 30) begin
      n_err++; $display("FAIL bound_p101 got oa=%0d co=%0d so=%0d want 101/20/30", o.oa, o.co, o.so); end
    send(-101, 20, 30, o);
    n_vec++; if (o.oa !== -101 || o.co !== 20 || o.so !== 30) begin
      n_err++; $display("FAIL bound_m101 got oa=%0d co=%0d so=%0d want -101/20/30", o.oa, o.co, o.so); end
    send(-102, 20, -30, o);
    n_vec++; if (o.oa !== 99 || o.co !== -20 || o.so !== 30) begin
      n_err++; $display("FAIL bound_m102 got oa=%0d co=%0d so=%0d want 99/-20/30", o.oa, o.co, o.so); end
    send(102, -7, 9, o);
    n_vec++; if (o.oa !== -99 || o.co !== 7 || o.so !== -9) begin
      n_err++; $display("FAIL bound_p102 got oa=%0d co=%0d so=%0d want -99/7/-9", o.oa, o.co, o.so); end
  endtask

  task automatic test_range();
    obs_t o;
    int   exp_oa_p, exp_oa_m;
    logic exp_err;
`ifdef CORDIC_RR_SAT_EN
    exp_oa_p = 0;  exp_oa_m = 0;   exp_err = 1'b1;
`else
    exp_oa_p = 99; exp_oa_m = -99; exp_err = 1'b0;
`endif
    send(300, 40, -10, o);
    n_vec++; if (o.oa !== DW'(exp_oa_p) || o.re !== exp_err || o.co !== -40 || o.so !== 10) begin
      n_err++; $display("FAIL range_p300 got oa=%0d re=%b co=%0d so=%0d want %0d/%b/-40/10",
                        o.oa, o.re, o.co, o.so, exp_oa_p, exp_err); end
    send(-300, 12, 3, o);
    n_vec++; if (o.oa !== DW'(exp_oa_m) || o.re !== exp_err || o.co !== -12 || o.so !== -3) begin
      n_err++; $display("FAIL range_m300 got oa=%0d re=%b co=%0d so=%0d want %0d/%b/-12/-3",
                        o.oa, o.re, o.co, o.so, exp_oa_m, exp_err); end
  endtask

  task automatic test_saturate();
    obs_t o;
    send(150, -128, -128, o);
    n_vec++; if (o.co !== 127 || o.so !== 127) begin
      n_err++; $display("FAIL sat_flip got co=%0d so=%0d want 127/127", o.co, o.so); end
    send(30, -128, 127, o);
    n_vec++; if (o.co !== -128 || o.so !== 127) begin
      n_err++; $display("FAIL sat_noflip got co=%0d so=%0d want -128/127", o.co, o.so); end
  endtask

  task automatic test_back_to_back();
    int a, r, c, s;
    logic exp_ov, exp_rv;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = i - 1;
      exp_ov = (a >= 0 && a < 20 && a != 8);
      n_vec++; if (out_valid !== exp_ov) begin
        n_err++; $display("FAIL b2b out_valid cyc %0d got %b want %b", i, out_valid, exp_ov); end
      if (exp_ov) begin
        n_vec++; if (out_angle !== DW'(RED[a])) begin
          n_err++; $display("FAIL b2b out_angle cyc %0d got %0d want %0d", i, out_angle, RED[a]); end
      end
      if (i == 9) begin
        n_vec++; if (out_angle !== 0 || cos_out !== 0 || sin_out !== 0 || res_err !== 1'b0) begin
          n_err++; $display("FAIL b2b cleared got oa=%0d co=%0d so=%0d re=%b want 0", out_angle, cos_out, sin_out, res_err); end
      end
      r = i - 14;
      exp_rv = (r >= 9 && r < 20);
      n_vec++; if (res_valid !== exp_rv) begin
        n_err++; $display("FAIL b2b res_valid cyc %0d got %b want %b", i, res_valid, exp_rv); end
      if (exp_rv) begin
        c = 3 * r - 30;
        s = 50 - 4 * r;
        if (FLIP[r] == 1) begin c = -c; s = -s; end
        n_vec++; if (cos_out !== DW'(c) || sin_out !== DW'(s) || res_err !== 1'b0) begin
          n_err++; $display("FAIL b2b res cyc %0d got co=%0d so=%0d re=%b want %0d/%0d/0", i, cos_out, sin_out, res_err, c, s); end
      end
      if (i < 20) begin
        in_valid = 1'b1;
        in_angle = IW'(ANG[i]);
        cur_cos  = DW'(3 * i - 30);
        cur_sin  = DW'(50 - 4 * i);
        rst      = (i == 8) ? 1'b0 : 1'b1;
        if (i == 8) begin
          #1;
          n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b in_ready in reset got %b want 0", in_ready); end
        end
      end else begin
        in_valid = 1'b0;
        cur_cos  = '0;
        cur_sin  = '0;
        rst      = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flip();
    test_boundary();
    test_range();
    test_saturate();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
